// File: rtl/read_hazard_unit.sv
// Purpose: tracks destinations of instructions in EX/MEM/WB and compares them with ID-stage
//          sources to raise the load-use stall and register the EX operand forwarding selects.
// Latency: Stall is combinational from the ID inputs; ForwardA/B and StallCount lag issue by one cycle.
module read_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IssueValid,
    input  logic             IssueRegWrite,
    input  logic             IssueMemRead,
    input  logic [REG_W-1:0] IssueWriteReg,
    input  logic [REG_W-1:0] ReadRs,
    input  logic [REG_W-1:0] ReadRt,
    input  logic             UseRs,
    input  logic             UseRt,
    input  logic             Flush,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount
);

    // Operand mux encodings seen by the EX stage.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Shadow pipeline state. EX and MEM carry the load flag because the
    // load-use check needs it in EX; nothing looks at load-ness once an
    // instruction has left MEM, so WB keeps only valid/regwrite/dst.
    // ------------------------------------------------------------------
    logic             ex_vld_q,  ex_vld_d;
    logic             ex_rw_q,   ex_rw_d;
    logic             ex_mr_q,   ex_mr_d;
    logic [REG_W-1:0] ex_dst_q,  ex_dst_d;

    logic             mem_vld_q, mem_vld_d;
    logic             mem_rw_q,  mem_rw_d;
    logic             mem_mr_q,  mem_mr_d;
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;

    logic             wb_vld_q,  wb_vld_d;
    logic             wb_rw_q,   wb_rw_d;
    logic [REG_W-1:0] wb_dst_q,  wb_dst_d;

    logic [1:0]       fwd_a_q,   fwd_a_d;
    logic [1:0]       fwd_b_q,   fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Per-source match against each producer stage.
    logic rs_ex_hit, rs_mem_hit, rs_wb_hit;
    logic rt_ex_hit, rt_mem_hit, rt_wb_hit;
    logic hazard_rs, hazard_rt;
    logic accept;

    // A producer feeds a source only if it is live, writes a register,
    // targets that register, and the register is not the hardwired $0.
    function automatic logic producer_hit(
        input logic             vld,
        input logic             rw,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] src
    );
        return vld & rw & (dst == src) & (src != '0);
    endfunction

    // Newest producer wins. A WB hit needs no bypass because the register
    // file writes in the first half of the cycle and ID reads the new value.
    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end else if (wb_hit) begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Compare the ID sources against every in-flight destination.
    always_comb begin
        rs_ex_hit  = producer_hit(ex_vld_q,  ex_rw_q,  ex_dst_q,  ReadRs);
        rs_mem_hit = producer_hit(mem_vld_q, mem_rw_q, mem_dst_q, ReadRs);
        rs_wb_hit  = producer_hit(wb_vld_q,  wb_rw_q,  wb_dst_q,  ReadRs);
        rt_ex_hit  = producer_hit(ex_vld_q,  ex_rw_q,  ex_dst_q,  ReadRt);
        rt_mem_hit = producer_hit(mem_vld_q, mem_rw_q, mem_dst_q, ReadRt);
        rt_wb_hit  = producer_hit(wb_vld_q,  wb_rw_q,  wb_dst_q,  ReadRt);
    end

    // Load-use stall: a load in EX feeding a consumed ID source. Flush wins,
    // and reset suppresses it so no stall is seen while tracking is cleared.
    always_comb begin
        hazard_rs = UseRs & ex_mr_q & rs_ex_hit;
        hazard_rt = UseRt & ex_mr_q & rt_ex_hit;
        Stall     = ~reset & ~Flush & (hazard_rs | hazard_rt);
        accept    = IssueValid & ~Stall & ~Flush;
    end

    // Advance the shadow pipeline; EX gets the ID instruction or a bubble.
    always_comb begin
        wb_vld_d  = mem_vld_q;
        wb_rw_d   = mem_rw_q;
        wb_dst_d  = mem_dst_q;

        mem_vld_d = ex_vld_q;
        mem_rw_d  = ex_rw_q;
        mem_mr_d  = ex_mr_q;
        mem_dst_d = ex_dst_q;

        ex_vld_d  = accept;
        ex_rw_d   = IssueRegWrite;
        ex_mr_d   = IssueMemRead;
        ex_dst_d  = IssueWriteReg;
    end

    // Forwarding selects for the instruction entering EX. An EX-stage match
    // only counts when the operand is consumed; reaching this point with an
    // EX load match is impossible because the stall blocks the accept.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (accept) begin
            fwd_a_d = fwd_sel(UseRs & rs_ex_hit, rs_mem_hit, rs_wb_hit);
            fwd_b_d = fwd_sel(UseRt & rt_ex_hit, rt_mem_hit, rt_wb_hit);
        end
    end

    // Saturating count of stall cycles for performance monitoring.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops all in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_vld_q    <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_dst_q    <= '0;
            mem_vld_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            mem_dst_q   <= '0;
            wb_vld_q    <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_dst_q    <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_vld_q    <= ex_vld_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_dst_q    <= ex_dst_d;
            mem_vld_q   <= mem_vld_d;
            mem_rw_q    <= mem_rw_d;
            mem_mr_q    <= mem_mr_d;
            mem_dst_q   <= mem_dst_d;
            wb_vld_q    <= wb_vld_d;
            wb_rw_q     <= wb_rw_d;
            wb_dst_q    <= wb_dst_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ForwardA   = fwd_a_q;
    assign ForwardB   = fwd_b_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_read_hazard_unit.sv
// Bench for read_hazard_unit built with a 4-bit stall counter so saturation is reachable.
// Directed vectors from a table, a saturation run, then random traffic against a queue model.
module tb_read_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             IssueValid, IssueRegWrite, IssueMemRead;
    logic [REG_W-1:0] IssueWriteReg, ReadRs, ReadRt;
    logic             UseRs, UseRt, Flush;
    logic             Stall;
    logic [1:0]       ForwardA, ForwardB;
    logic [CNT_W-1:0] StallCount;

    read_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite), .IssueMemRead(IssueMemRead),
        .IssueWriteReg(IssueWriteReg), .ReadRs(ReadRs), .ReadRt(ReadRt),
        .UseRs(UseRs), .UseRt(UseRt), .Flush(Flush),
        .Stall(Stall), .ForwardA(ForwardA), .ForwardB(ForwardB), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, v, rw, mr;
        logic [4:0] wr, rs, rt;
        logic       urs, urt, fl;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic       st;
        logic [1:0] fa, fb;
        logic [3:0] cnt;
    } vec_t;

    typedef struct packed {
        logic       v, rw, mr;
        logic [4:0] dst;
    } rec_t;

    vec_t vecs[$];
    rec_t hist[$];          // hist[0] = instruction now in EX, hist[1] = in MEM
    int   m_fa, m_fb, m_cnt;
    logic m_stall;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, v, rw, mr, input int wr, rs, rt,
                       input logic urs, urt, fl, st, input int fa, fb, cnt);
        vec_t t;
        t.i.rst = rst; t.i.v = v; t.i.rw = rw; t.i.mr = mr;
        t.i.wr = 5'(wr); t.i.rs = 5'(rs); t.i.rt = 5'(rt);
        t.i.urs = urs; t.i.urt = urt; t.i.fl = fl;
        t.st = st; t.fa = 2'(fa); t.fb = 2'(fb); t.cnt = 4'(cnt);
        vecs.push_back(t);
    endtask

    function automatic rec_t stage(input int idx);
        rec_t b;
        b = '0;
        if (hist.size() > idx) b = hist[idx];
        return b;
    endfunction

    function automatic bit feeds(input rec_t p, input logic [4:0] src);
        return p.v && p.rw && (p.dst == src) && (src != 0);
    endfunction

    // Newest producer that the rules allow; WB never needs a bypass.
    function automatic int pick(input logic use_src, input logic [4:0] src);
        if (use_src && feeds(stage(0), src)) return 2;
        if (feeds(stage(1), src)) return 1;
        return 0;
    endfunction

    // One clock: drive at negedge, check Stall before the edge, registers after it.
    task automatic cycle(input in_t x, input bit use_model, input logic e_st,
                         input int e_fa, e_fb, e_cnt, input string tag);
        bit   acc;
        rec_t r;
        reset = x.rst; IssueValid = x.v; IssueRegWrite = x.rw; IssueMemRead = x.mr;
        IssueWriteReg = x.wr; ReadRs = x.rs; ReadRt = x.rt;
        UseRs = x.urs; UseRt = x.urt; Flush = x.fl;
        #1;
        m_stall = !x.rst && !x.fl && stage(0).mr &&
                  ((x.urs && feeds(stage(0), x.rs)) || (x.urt && feeds(stage(0), x.rt)));
        chk({tag, ".stall"}, int'(Stall), use_model ? int'(m_stall) : int'(e_st));
        @(posedge clk);
        if (x.rst) begin
            hist.delete();
            m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            acc  = x.v && !m_stall && !x.fl;
            m_fa = acc ? pick(x.urs, x.rs) : 0;
            m_fb = acc ? pick(x.urt, x.rt) : 0;
            r.v = acc; r.rw = x.rw; r.mr = x.mr; r.dst = x.wr;
            hist.push_front(r);
            if (hist.size() > 3) void'(hist.pop_back());
            if (m_stall && m_cnt < CMAX) m_cnt++;
        end
        #1;
        chk({tag, ".fwdA"},  int'(ForwardA),   use_model ? m_fa  : e_fa);
        chk({tag, ".fwdB"},  int'(ForwardB),   use_model ? m_fb  : e_fb);
        chk({tag, ".count"}, int'(StallCount), use_model ? m_cnt : e_cnt);
        @(negedge clk);
    endtask

    initial begin
        in_t x;
        reset = 1'b1; IssueValid = 1'b0; IssueRegWrite = 1'b0; IssueMemRead = 1'b0;
        IssueWriteReg = '0; ReadRs = '0; ReadRt = '0; UseRs = 1'b0; UseRt = 1'b0; Flush = 1'b0;
        m_fa = 0; m_fb = 0; m_cnt = 0; m_stall = 1'b0;

        //   rst v rw mr  wr  rs  rt urs urt fl | st fa fb cnt
        add(1, 1, 1, 0,  5,  1,  2, 1, 1, 0,   0, 0, 0, 0); // reset with valid issue
        add(1, 1, 1, 0,  5,  1,  2, 1, 1, 0,   0, 0, 0, 0);
        add(0, 1, 1, 0,  5,  1,  2, 1, 1, 0,   0, 0, 0, 0); // add -> $5
        add(0, 1, 1, 0, 10,  5,  6, 1, 1, 0,   0, 2, 0, 0); // sub reads $5: EX bypass
        add(0, 1, 1, 0,  7,  1,  2, 1, 1, 0,   0, 0, 0, 0); // writer $7
        add(0, 1, 1, 0, 11, 12, 13, 1, 1, 0,   0, 0, 0, 0); // unrelated
        add(0, 1, 1, 0, 14, 15,  7, 1, 1, 0,   0, 0, 1, 0); // reads $7 on Rt: MEM bypass
        add(0, 1, 1, 1,  8,  1,  2, 1, 1, 0,   0, 0, 0, 0); // lw -> $8
        add(0, 1, 1, 0, 16,  8,  8, 1, 1, 0,   1, 0, 0, 1); // load-use on both: one stall
        add(0, 1, 1, 0, 16,  8,  8, 1, 1, 0,   0, 1, 1, 1); // re-issue gets WB data
        add(0, 1, 1, 0,  3,  1,  2, 1, 1, 0,   0, 0, 0, 1); // writer $3
        add(0, 1, 1, 0,  3,  1,  2, 1, 1, 0,   0, 0, 0, 1); // writer $3 again
        add(0, 1, 1, 0, 17,  3,  0, 1, 0, 0,   0, 2, 0, 1); // newest writer wins
        add(0, 1, 1, 0,  0,  1,  2, 1, 1, 0,   0, 0, 0, 1); // writer $0
        add(0, 1, 1, 0, 18,  0,  0, 1, 1, 0,   0, 0, 0, 1); // reader $0: no bypass
        add(0, 1, 1, 1,  0,  1,  2, 1, 1, 0,   0, 0, 0, 1); // lw -> $0
        add(0, 1, 1, 0, 19,  0,  0, 1, 1, 0,   0, 0, 0, 1); // reader $0: no stall
        add(0, 1, 1, 1,  9,  1,  2, 1, 1, 0,   0, 0, 0, 1); // lw -> $9
        add(0, 1, 1, 0, 20,  9,  9, 1, 1, 1,   0, 0, 0, 1); // hazard + flush: flush wins
        add(0, 1, 1, 0, 20,  9,  9, 1, 1, 0,   0, 1, 1, 1); // lw now in MEM
        add(0, 1, 1, 1, 10,  1,  2, 1, 1, 0,   0, 0, 0, 1); // lw -> $10
        add(1, 1, 1, 0, 21, 10,  1, 1, 1, 0,   0, 0, 0, 0); // reset over a hazard
        add(0, 1, 1, 0, 21, 10,  1, 1, 1, 0,   0, 0, 0, 0); // tracking was discarded

        @(negedge clk);
        foreach (vecs[k]) begin
            cycle(vecs[k].i, 1'b0, vecs[k].st, vecs[k].fa, vecs[k].fb, vecs[k].cnt,
                  $sformatf("vec%0d", k));
        end

        // Chain of loads each consuming the previous one: a stall every other cycle.
        x = '0;
        x.v = 1; x.rw = 1; x.mr = 1; x.wr = 8; x.rs = 8; x.urs = 1;
        for (int k = 0; k < 44; k++) cycle(x, 1'b1, 1'b0, 0, 0, 0, "sat");
        chk("sat.final", int'(StallCount), CMAX);

        // Random traffic over a small register range to force collisions.
        for (int k = 0; k < 1500; k++) begin
            x.rst = ($urandom_range(0, 63) == 0);
            x.v   = ($urandom_range(0, 7) != 0);
            x.rw  = ($urandom_range(0, 3) != 0);
            x.mr  = ($urandom_range(0, 2) == 0);
            x.wr  = 5'($urandom_range(0, 3));
            x.rs  = 5'($urandom_range(0, 3));
            x.rt  = 5'($urandom_range(0, 3));
            x.urs = $urandom_range(0, 1);
            x.urt = $urandom_range(0, 1);
            x.fl  = ($urandom_range(0, 7) == 0);
            cycle(x, 1'b1, 1'b0, 0, 0, 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
